// File: rtl/adder_pkg.sv
// Shared definitions for the serial multiword adder: FSM states and
// the helper that sizes the slice counter.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int num_slices);
        return (num_slices <= 2) ? 1 : $clog2(num_slices);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder used as the single shared slice datapath.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Serial add/subtract of OPERAND_WIDTH operands, one SLICE_WIDTH slice per
// cycle (LSB first) through one shared ripple_carry_adder.
module multiword_add_sequencer
    import adder_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int SLICE_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_a,
    input  logic [OPERAND_WIDTH-1:0] in_b,
    input  logic                     in_c,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_sum,
    output logic                     out_c,
    output logic                     out_ovf
);

    localparam int NUM_SLICES = OPERAND_WIDTH / SLICE_WIDTH;
    localparam int CNT_W      = cnt_width(NUM_SLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     carry_q, carry_d;
    logic [OPERAND_WIDTH-1:0] a_q, a_d;
    logic [OPERAND_WIDTH-1:0] b_eff_q, b_eff_d;
    logic [OPERAND_WIDTH-1:0] acc_q, acc_d;
    logic [OPERAND_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                     out_c_q, out_c_d;
    logic                     out_ovf_q, out_ovf_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;

    logic [SLICE_WIDTH-1:0]   slice_sum;
    logic                     slice_cout;

    // Operands shift right each cycle so the active slice is always at bit 0;
    // after the last slice the MSB slice of a/b_eff is still in the low bits.
    ripple_carry_adder #(.WIDTH(SLICE_WIDTH)) u_slice_adder (
        .a    (a_q[SLICE_WIDTH-1:0]),
        .b    (b_eff_q[SLICE_WIDTH-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_eff_d     = b_eff_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_c_d     = out_c_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_eff_d = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_c;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {slice_sum, acc_q[OPERAND_WIDTH-1:SLICE_WIDTH]};
                a_d     = a_q >> SLICE_WIDTH;
                b_eff_d = b_eff_q >> SLICE_WIDTH;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    out_sum_d   = acc_d;
                    out_c_d     = slice_cout;
                    out_ovf_d   = (a_q[SLICE_WIDTH-1] == b_eff_q[SLICE_WIDTH-1]) &&
                                  (slice_sum[SLICE_WIDTH-1] != a_q[SLICE_WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_eff_q     <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_c_q     <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_eff_q     <= b_eff_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_c_q     <= out_c_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_c     = out_c_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer at 32-bit operands, 8-bit slices.
module tb_multiword_add_sequencer;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_c = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_c;
    logic         out_ovf;

    int total = 0;
    int bad   = 0;

    multiword_add_sequencer #(.OPERAND_WIDTH(W), .SLICE_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; it is taken at the next rising edge.
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic sub);
        @(negedge clk);
        in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // out_valid must stay low for N-1 edges and rise on edge N after accept.
    task automatic wait_latency(input string tag);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            if (k < N) check({tag, "_early_valid"}, out_valid, 0);
        end
        check({tag, "_valid_at_N"}, out_valid, 1);
        check({tag, "_busy_ready"}, in_ready, 0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] s, input logic c, input logic ovf);
        check({tag, "_sum"}, out_sum, s);
        check({tag, "_c"},   out_c, c);
        check({tag, "_ovf"}, out_ovf, ovf);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic sub,
                           input logic [W-1:0] s, input logic co, input logic ovf);
        start_op(tag, a, b, c, sub);
        wait_latency(tag);
        check_result(tag, s, co, ovf);
        handshake(tag);
    endtask

    initial begin
        logic [W-1:0] held_sum;

        // Reset state
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_sum",   out_sum, 0);
        check("rst_c",     out_c, 0);
        check("rst_ovf",   out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry across one slice boundary, then through all slices
        full_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        full_op("add_chain",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        full_op("add_ovf",    32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
        // Subtraction; in_c must be ignored in subtract mode
        full_op("sub_5_7",    32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        full_op("sub_7_5",    32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
        full_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Backpressure: hold DONE for 5 cycles while in_valid pulses arrive
        start_op("bp", 32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0);
        wait_latency("bp");
        check_result("bp", 32'h10101010, 1'b0, 1'b0);
        held_sum = out_sum;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_sum",   out_sum, held_sum);
            check("bp_hold_c",     out_c, 0);
            check("bp_hold_ovf",   out_ovf, 0);
        end
        handshake("bp");
        // Accept on the very next edge after the handshake
        full_op("bp_next", 32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);

        // Reset mid-RUN at cnt=2 discards the operation
        start_op("rst_run", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_run_valid", out_valid, 0);
        check("rst_run_ready", in_ready, 1);
        check("rst_run_sum",   out_sum, 0);
        check("rst_run_c",     out_c, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("rst_run_no_result", out_valid, 0);
        end
        check("rst_run_ready_after", in_ready, 1);
        full_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
